// File: rtl/vx_gpu_pkg.sv
// Shared tensor-core geometry and tile types for the octet datapath.
package vx_gpu_pkg;

  localparam int TENSOR_ROWS   = 4;
  localparam int TENSOR_COLS   = 4;
  localparam int TENSOR_K      = 2;
  localparam int TENSOR_ELEM_W = 32;

  typedef logic [TENSOR_ELEM_W-1:0] tensor_elem_t;

  // A[row][k], B[k][col], C/D[row][col]
  typedef logic [TENSOR_ROWS-1:0][TENSOR_K-1:0][TENSOR_ELEM_W-1:0]    tensor_a_tile_t;
  typedef logic [TENSOR_K-1:0][TENSOR_COLS-1:0][TENSOR_ELEM_W-1:0]    tensor_b_tile_t;
  typedef logic [TENSOR_ROWS-1:0][TENSOR_COLS-1:0][TENSOR_ELEM_W-1:0] tensor_cd_tile_t;

endpackage

// File: rtl/vx_tensor_dot_lane.sv
// One D element: S2 holds the two truncated products plus C, S3 holds their wrapping sum.
module vx_tensor_dot_lane
  import vx_gpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en_s2_i,
  input  logic         en_s3_i,
  input  tensor_elem_t a0_i,
  input  tensor_elem_t a1_i,
  input  tensor_elem_t b0_i,
  input  tensor_elem_t b1_i,
  input  tensor_elem_t c_i,
  output tensor_elem_t d_o
);

  tensor_elem_t p0_d, p1_d, sum_d;
  tensor_elem_t p0_q, p1_q, c_q, sum_q;

  // 32x32 products assigned to 32-bit targets keep only the low word.
  always_comb begin
    p0_d  = a0_i * b0_i;
    p1_d  = a1_i * b1_i;
    sum_d = c_q + p0_q + p1_q;
  end

  // NOTE: pure data registers carry no reset; the valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (en_s2_i) begin
      p0_q <= p0_d;
      p1_q <= p1_d;
      c_q  <= c_i;
    end
  end

  // The sum register is the output register when LATENCY=3, so it must clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (en_s3_i) begin
      sum_q <= sum_d;
    end
  end

  assign d_o = sum_q;

endmodule

// File: rtl/vx_tensor_dot_pipe.sv
// D = A x B + C tile pipeline (4x2 by 2x4 plus 4x4), fixed latency, global stall.
module vx_tensor_dot_pipe
  import vx_gpu_pkg::*;
#(
  parameter int LATENCY = 4,  // legal 3..8
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             valid_in,
  input  tensor_a_tile_t   A_tile,
  input  tensor_b_tile_t   B_tile,
  input  tensor_cd_tile_t  C_tile,
  output logic             valid_out,
  output tensor_cd_tile_t  D_tile,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  logic [LATENCY:1] valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  tensor_a_tile_t   a_q;
  tensor_b_tile_t   b_q;
  tensor_cd_tile_t  c_q;
  tensor_cd_tile_t  s3_tile;

  always_comb begin
    valid_d = {valid_q[LATENCY-1:1], valid_in};
  end

  // NOTE: every stage register uses <= so each stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && valid_in) begin
      a_q <= A_tile;
      b_q <= B_tile;
      c_q <= C_tile;
    end
  end

  for (genvar r = 0; r < TENSOR_ROWS; r++) begin : g_row
    for (genvar c = 0; c < TENSOR_COLS; c++) begin : g_col
      vx_tensor_dot_lane u_lane (
        .clk     (clk),
        .reset   (reset),
        .en_s2_i (!stall && valid_q[1]),
        .en_s3_i (!stall && valid_q[2]),
        .a0_i    (a_q[r][0]),
        .a1_i    (a_q[r][1]),
        .b0_i    (b_q[0][c]),
        .b1_i    (b_q[1][c]),
        .c_i     (c_q[r][c]),
        .d_o     (s3_tile[r][c])
      );
    end
  end

  if (LATENCY == 3) begin : g_no_delay
    assign D_tile = s3_tile;
  end else begin : g_delay
    localparam int NDLY = LATENCY - 3;
    tensor_cd_tile_t dly_q [NDLY];

    // NOTE: the whole delay memory is cleared, not just its last entry, so D_tile is 0 after reset at any LATENCY.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < NDLY; i++) dly_q[i] <= '0;
      end else if (!stall) begin
        if (valid_q[3]) dly_q[0] <= s3_tile;
        for (int i = 1; i < NDLY; i++) begin
          if (valid_q[i+3]) dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign D_tile = dly_q[NDLY-1];
  end

  // NOTE: cnt_d gets its hold value first so the conditional increment cannot infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_out && !stall) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign valid_out = valid_q[LATENCY];
  assign busy      = |valid_q;
  assign op_count  = cnt_q;

  // Operands offered during a stall are dropped; the octet must never do this.
  a_no_valid_under_stall : assert property (@(posedge clk) disable iff (reset) !(stall && valid_in));

endmodule

// File: tb/tb_vx_tensor_dot_pipe.sv
// Directed bench for vx_tensor_dot_pipe at LATENCY=4: latency, wrap arithmetic, stalls, streaming, reset.
module tb_vx_tensor_dot_pipe;
  import vx_gpu_pkg::*;

  localparam int LAT   = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             valid_in;
  tensor_a_tile_t   A_tile;
  tensor_b_tile_t   B_tile;
  tensor_cd_tile_t  C_tile;
  logic             valid_out;
  tensor_cd_tile_t  D_tile;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int               checks_total  = 0;
  int               checks_passed = 0;
  logic [CNT_W-1:0] exp_count     = '0;

  always #5 clk = ~clk;

  vx_tensor_dot_pipe #(.LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .valid_in  (valid_in),
    .A_tile    (A_tile),
    .B_tile    (B_tile),
    .C_tile    (C_tile),
    .valid_out (valid_out),
    .D_tile    (D_tile),
    .busy      (busy),
    .op_count  (op_count)
  );

  function automatic tensor_cd_tile_t fill(input logic [31:0] v);
    tensor_cd_tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = v;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uniform(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 2; k++) A_tile[r][k] = a;
    for (int k = 0; k < 2; k++)
      for (int c2 = 0; c2 < 4; c2++) B_tile[k][c2] = b;
    C_tile   = fill(c);
    valid_in = 1'b1;
  endtask

  task automatic test_reset();
    checks_total++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", valid_out);
    else checks_passed++;
    checks_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else checks_passed++;
    checks_total++;
    if (op_count !== '0) $display("FAIL reset_op_count: got %0d want 0", op_count);
    else checks_passed++;
    checks_total++;
    if (D_tile !== '0) $display("FAIL reset_d_tile: got %h want 0", D_tile);
    else checks_passed++;
  endtask

  task automatic test_identity();
    tensor_cd_tile_t exp_d;
    // A[r] = {r*4, 1}, B[0][c] = c, B[1][c] = 1, C = 0  ->  D[r][c] = r*4 + c
    for (int r = 0; r < 4; r++) begin
      A_tile[r][0] = 32'd1;
      A_tile[r][1] = 32'(r * 4);
      for (int c = 0; c < 4; c++) exp_d[r][c] = 32'(r * 4 + c);
    end
    for (int c = 0; c < 4; c++) begin
      B_tile[0][c] = 32'(c);
      B_tile[1][c] = 32'd1;
    end
    C_tile   = '0;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    checks_total++;
    if (busy !== 1'b1) $display("FAIL ident_busy_inflight: got %b want 1", busy);
    else checks_passed++;
    for (int i = 0; i < LAT - 2; i++) begin
      step();
      checks_total++;
      if (valid_out !== 1'b0) $display("FAIL ident_early_valid: cycle %0d got %b want 0", i, valid_out);
      else checks_passed++;
    end
    step();
    checks_total++;
    if (valid_out !== 1'b1) $display("FAIL ident_valid_out: got %b want 1", valid_out);
    else checks_passed++;
    checks_total++;
    if (D_tile !== exp_d) $display("FAIL ident_d_tile: got %h want %h", D_tile, exp_d);
    else checks_passed++;
    step();
    exp_count++;
    checks_total++;
    if (op_count !== exp_count) $display("FAIL ident_op_count: got %0d want %0d", op_count, exp_count);
    else checks_passed++;
    checks_total++;
    if (busy !== 1'b0 || valid_out !== 1'b0)
      $display("FAIL ident_drained: got busy=%b valid=%b want 0 0", busy, valid_out);
    else checks_passed++;
    checks_total++;
    if (D_tile !== exp_d) $display("FAIL ident_d_hold: got %h want %h", D_tile, exp_d);
    else checks_passed++;
  endtask

  task automatic test_wrap();
    drive_uniform(32'h0001_0000, 32'h0001_0000, 32'd5);
    step();
    drive_uniform(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    step();
    valid_in = 1'b0;
    for (int i = 0; i < LAT - 3; i++) step();
    step();
    checks_total++;
    if (valid_out !== 1'b1 || D_tile !== fill(32'd5))
      $display("FAIL wrap_trunc: got valid=%b d=%h want valid=1 all 5", valid_out, D_tile);
    else checks_passed++;
    step();
    checks_total++;
    if (valid_out !== 1'b1 || D_tile !== fill(32'd2))
      $display("FAIL wrap_neg: got valid=%b d=%h want valid=1 all 2", valid_out, D_tile);
    else checks_passed++;
    step();
    exp_count += 2;
    checks_total++;
    if (op_count !== exp_count) $display("FAIL wrap_op_count: got %0d want %0d", op_count, exp_count);
    else checks_passed++;
  endtask

  task automatic test_stall();
    tensor_cd_tile_t x;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) x[r][c] = 32'(32'h100 + r * 4 + c);
    drive_uniform(32'd0, 32'd0, 32'd0);
    C_tile = x;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < LAT - 2; i++) step();
    step();
    checks_total++;
    if (valid_out !== 1'b1 || D_tile !== x)
      $display("FAIL stall_first_out: got valid=%b d=%h want valid=1 d=%h", valid_out, D_tile, x);
    else checks_passed++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks_total++;
      if (valid_out !== 1'b1 || D_tile !== x || op_count !== exp_count)
        $display("FAIL stall_frozen: cycle %0d got valid=%b cnt=%0d want valid=1 cnt=%0d",
                 i, valid_out, op_count, exp_count);
      else checks_passed++;
    end
    stall = 1'b0;
    step();
    exp_count++;
    checks_total++;
    if (op_count !== exp_count || valid_out !== 1'b0)
      $display("FAIL stall_release: got cnt=%0d valid=%b want cnt=%0d valid=0", op_count, valid_out, exp_count);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    for (int n = 0; n <= 9 + LAT; n++) begin
      drive_uniform(32'd0, 32'd0, 32'(n));
      valid_in = (n < 10);
      step();
      exp_v = (n >= LAT - 1) && (n <= 9 + LAT - 1);
      checks_total++;
      if (valid_out !== exp_v) $display("FAIL stream_valid: cycle %0d got %b want %b", n, valid_out, exp_v);
      else checks_passed++;
      if (exp_v) begin
        checks_total++;
        if (D_tile !== fill(32'(n - (LAT - 1))))
          $display("FAIL stream_d: cycle %0d got %h want all %0d", n, D_tile, n - (LAT - 1));
        else checks_passed++;
      end
    end
    valid_in = 1'b0;
    exp_count += 10;
    checks_total++;
    if (op_count !== exp_count || busy !== 1'b0)
      $display("FAIL stream_end: got cnt=%0d busy=%b want cnt=%0d busy=0", op_count, busy, exp_count);
    else checks_passed++;
  endtask

  task automatic test_bubble_stall();
    logic exp_v;
    // Ops accepted at edges 0 and 2, stall on edges 3 and 4: outputs at edges LAT+1 and LAT+3.
    for (int n = 0; n <= LAT + 4; n++) begin
      drive_uniform(32'd0, 32'd0, (n == 0) ? 32'hA0 : 32'hB0);
      valid_in = (n == 0) || (n == 2);
      stall    = (n == 3) || (n == 4);
      step();
      exp_v = (n == LAT + 1) || (n == LAT + 3);
      checks_total++;
      if (valid_out !== exp_v) $display("FAIL bubble_valid: cycle %0d got %b want %b", n, valid_out, exp_v);
      else checks_passed++;
      if (n == LAT + 1 || n == LAT + 2) begin
        checks_total++;
        if (D_tile !== fill(32'hA0)) $display("FAIL bubble_d_first: cycle %0d got %h want all a0", n, D_tile);
        else checks_passed++;
      end else if (n == LAT + 3) begin
        checks_total++;
        if (D_tile !== fill(32'hB0)) $display("FAIL bubble_d_second: cycle %0d got %h want all b0", n, D_tile);
        else checks_passed++;
      end
    end
    valid_in = 1'b0;
    stall    = 1'b0;
    exp_count += 2;
    checks_total++;
    if (op_count !== exp_count) $display("FAIL bubble_op_count: got %0d want %0d", op_count, exp_count);
    else checks_passed++;
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 3; n++) begin
      drive_uniform(32'd0, 32'd0, 32'(7 + n));
      step();
    end
    valid_in = 1'b0;
    step();
    checks_total++;
    if (valid_out !== 1'b1 || D_tile !== fill(32'd7))
      $display("FAIL areset_pre: got valid=%b d=%h want valid=1 all 7", valid_out, D_tile);
    else checks_passed++;
    #2 reset = 1'b1;
    #1;
    exp_count = '0;
    checks_total++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || op_count !== '0 || D_tile !== '0)
      $display("FAIL areset_immediate: got valid=%b busy=%b cnt=%0d d=%h want all 0",
               valid_out, busy, op_count, D_tile);
    else checks_passed++;
    step();
    #3 reset = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      checks_total++;
      if (valid_out !== 1'b0 || busy !== 1'b0 || op_count !== exp_count)
        $display("FAIL areset_after: cycle %0d got valid=%b busy=%b cnt=%0d want 0 0 0",
                 i, valid_out, busy, op_count);
      else checks_passed++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    valid_in = 1'b0;
    A_tile   = '0;
    B_tile   = '0;
    C_tile   = '0;
    step();
    test_reset();
    step();
    reset = 1'b0;
    step();
    test_identity();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_bubble_stall();
    test_async_reset();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
